lc4_timer_bank: RTL

Parametrised multi-channel memory-mapped timer for the LC4 system. It generalises the single-interval timer device to NUM_CH independent countdown channels. Each channel has one-shot or periodic mode, a shared prescaler, read-to-clear status, and per-channel expiry flags. It sits on the data-memory port beside the keyboard and the video memory, decodes its own address window, and supplies a combinational read word to the device mux.

---
 rtl/lc4_timer_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lc4_timer_bank.sv
// Multi-channel memory-mapped countdown timer bank for the LC4 data-memory port.
// Optional periodic reload mode is built only when LC4_TIMER_BANK_PERIODIC_EN is defined.
module lc4_timer_bank #(
    parameter int          NUM_CH    = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFE40,
    parameter int          PRESCALE  = 16000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gwe,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    input  logic              we,
    output logic [15:0]       rdata,
    output logic              hit,
    output logic [NUM_CH-1:0] expired,
    output logic              any_expired
);

    localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [16:0] WIN_END   = 17'(BASE_ADDR) + 17'(4 * NUM_CH);

    logic [PW-1:0]            presc_q;
    logic                     tick;
    logic [5:0]               offset;
    logic [NUM_CH-1:0]        flag_v;
    logic [NUM_CH-1:0]        en_v;
    logic [NUM_CH-1:0]        per_v;
    logic [NUM_CH-1:0][15:0]  int_v;
    logic [NUM_CH-1:0][15:0]  cnt_v;

    // Window base is a multiple of 4*NUM_CH, so the low offset bits select channel/register.
    assign offset = 6'(addr - BASE_ADDR);
    assign hit    = (addr >= BASE_ADDR) && (17'(addr) < WIN_END);
    assign tick   = gwe && (presc_q == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (gwe) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [15:0] interval_q;
        logic [15:0] count_q;
        logic        en_q;
        logic        per_q;
        logic        flag_q;
        logic        sel;
        logic        wr_int;
        logic        wr_ctl;
        logic        rd_stat;
        logic        en_next;
        logic        run;
        logic        fire;

        assign sel     = hit && (offset[5:2] == 4'(i));
        assign wr_int  = gwe && we && sel && (offset[1:0] == 2'd1);
        assign wr_ctl  = gwe && we && sel && (offset[1:0] == 2'd2);
        assign rd_stat = gwe && !we && sel && (offset[1:0] == 2'd0);
        assign en_next = wr_ctl ? wdata[0] : en_q;
        // A tick counts only if the channel is enabled both before and after this edge.
        assign run     = tick && en_q && en_next;
        assign fire    = run && (count_q <= 16'd1);

        always_ff @(posedge clk) begin
            if (rst) begin
                interval_q <= '0;
                count_q    <= '0;
                en_q       <= 1'b0;
                flag_q     <= 1'b0;
            end else if (wr_int) begin
                interval_q <= wdata;
                count_q    <= wdata;
                en_q       <= 1'b1;
                flag_q     <= 1'b0;
            end else if (gwe) begin
                en_q <= en_next;
                if (run) begin
                    if (!fire) begin
                        count_q <= count_q - 16'd1;
                    end else if (per_q) begin
                        count_q <= interval_q;
                    end else begin
                        count_q <= '0;
                        en_q    <= 1'b0;
                    end
                end
                if (fire) begin
                    flag_q <= 1'b1;
                end else if (rd_stat) begin
                    flag_q <= 1'b0;
                end
            end
        end

`ifdef LC4_TIMER_BANK_PERIODIC_EN
        always_ff @(posedge clk) begin
            if (rst) begin
                per_q <= 1'b0;
            end else if (wr_ctl) begin
                per_q <= wdata[1];
            end
        end
`else
        assign per_q = 1'b0;
`endif

        assign flag_v[i] = flag_q;
        assign en_v[i]   = en_q;
        assign per_v[i]  = per_q;
        assign int_v[i]  = interval_q;
        assign cnt_v[i]  = count_q;
    end

    always_comb begin
        rdata = '0;
        if (hit && !we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (offset[5:2] == 4'(i)) begin
                    case (offset[1:0])
                        2'd0:    rdata = {flag_v[i], 15'b0};
                        2'd1:    rdata = int_v[i];
                        2'd2:    rdata = {14'b0, per_v[i], en_v[i]};
                        default: rdata = cnt_v[i];
                    endcase
                end
            end
        end
    end

    assign expired     = flag_v;
    assign any_expired = |flag_v;

endmodule
